// File: rtl/uart_pkg.sv
// Shared types and helpers for the USB serial UART.
// Frame state enum, bit count and baud divisor function.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int UART_BITS = 8;

    function automatic int uart_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte store: circular FIFO with UART_RX_FIFO_EN, else one holding register.
// A push into a full store is refused unless a pop frees a slot in the same cycle.
import uart_pkg::*;

module uart_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of 2, at least 2");
    end

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [7:0]  mem [DEPTH];
    logic        wr_en;
    logic        rd_en;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (wr_en) begin
                mem[wptr[AW-1:0]] <= din;
                wptr <= wptr + 1'b1;
            end
            if (rd_en) begin
                rptr <= rptr + 1'b1;
            end
        end
    end
`else
    logic [7:0] hold;
    logic       valid;

    assign empty = !valid;
    assign full  = valid;
    assign dout  = hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold  <= 8'h00;
            valid <= 1'b0;
        end else if (push && (!valid || pop)) begin
            hold  <= din;
            valid <= 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/uart_usb_port.sv
// 8N1 UART for the USB serial channel; RX store depth set by UART_RX_FIFO_EN.
// Holds the rxd synchronizer, both frame FSMs, shift registers and sticky rx_err.
import uart_pkg::*;

module uart_usb_port #(
    parameter int CLK_HZ   = 11059200,
    parameter int BAUD     = 115200,
    parameter int RX_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_i,
    output logic       txd_o,
    input  logic [7:0] tx_data,
    input  logic       tx_write,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_read,
    output logic [1:0] status,
    output logic       rx_err
);

    localparam int          DIV       = uart_div(CLK_HZ, BAUD);
    localparam logic [6:0]  DIV_LAST  = 7'(DIV - 1);
    localparam logic [6:0]  HALF_LAST = 7'(DIV / 2 - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(UART_BITS - 1);

    logic [1:0]  sync;
    logic        rx_s;
    logic        rx_prev;

    uart_state_t rx_state, rx_state_n;
    logic [6:0]  rx_cnt, rx_cnt_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_push;
    logic        frame_err;

    uart_state_t tx_state, tx_state_n;
    logic [6:0]  tx_cnt, tx_cnt_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;

    logic        st_empty;
    logic        st_full;
    logic        rx_pop;
    logic        overrun;

    assign rx_s     = sync[1];
    assign rx_valid = !st_empty;
    assign rx_pop   = rx_read && rx_valid;
    assign overrun  = rx_push && st_full && !rx_pop;
    assign status   = {rx_valid, tx_ready};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync     <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            sync     <= {sync[0], rxd_i};
            rx_prev  <= rx_s;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 7'd1;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        frame_err  = 1'b0;
        unique case (rx_state)
            IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s) begin
                    rx_state_n = START;
                end
            end
            START: begin
                // Mid-start-bit recheck filters short glitches silently
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_cnt == DIV_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == LAST_BIT) begin
                        rx_state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (rx_cnt == DIV_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = IDLE;
                    rx_push    = rx_s;
                    frame_err  = !rx_s;
                end
            end
        endcase
    end

    uart_rx_fifo #(
        .DEPTH(RX_DEPTH)
    ) u_store (
        .clk  (clk),
        .rst  (rst),
        .push (rx_push),
        .pop  (rx_pop),
        .din  (rx_shift),
        .dout (rx_data),
        .empty(st_empty),
        .full (st_full)
    );

    // A new error in the same cycle as a read must survive
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_err <= 1'b0;
        end else if (frame_err || overrun) begin
            rx_err <= 1'b1;
        end else if (rx_read) begin
            rx_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 7'd1;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_ready   = 1'b0;
        txd_o      = 1'b1;
        unique case (tx_state)
            IDLE: begin
                tx_ready = 1'b1;
                tx_cnt_n = '0;
                if (tx_write) begin
                    tx_shift_n = tx_data;
                    tx_state_n = START;
                end
            end
            START: begin
                txd_o = 1'b0;
                if (tx_cnt == DIV_LAST) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = DATA;
                end
            end
            DATA: begin
                txd_o = tx_shift[0];
                if (tx_cnt == DIV_LAST) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = {1'b1, tx_shift[7:1]};
                    tx_bit_n   = tx_bit + 3'd1;
                    if (tx_bit == LAST_BIT) begin
                        tx_state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (tx_cnt == DIV_LAST) begin
                    tx_cnt_n   = '0;
                    tx_state_n = IDLE;
                end
            end
        endcase
    end

endmodule
